// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// The lock signal exists only when RR_ARB_LOCK_EN is defined.
interface wrr_arbiter_if #(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned WEIGHT_W = 3
);
  localparam int unsigned IDX_W = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0]          reqs;
  logic [NUM_REQS*WEIGHT_W-1:0] weights;
  logic                         ack;
`ifdef RR_ARB_LOCK_EN
  logic                         lock;
`endif
  logic [NUM_REQS-1:0]          grants;
  logic                         grant_valid;
  logic [IDX_W-1:0]             grant_idx;
  logic [WEIGHT_W-1:0]          credit_left;

`ifdef RR_ARB_LOCK_EN
  modport master (output reqs, weights, ack, lock,
                  input  grants, grant_valid, grant_idx, credit_left);
  modport slave  (input  reqs, weights, ack, lock,
                  output grants, grant_valid, grant_idx, credit_left);
`else
  modport master (output reqs, weights, ack,
                  input  grants, grant_valid, grant_idx, credit_left);
  modport slave  (input  reqs, weights, ack,
                  output grants, grant_valid, grant_idx, credit_left);
`endif
endinterface

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker: first set request scanning from start, wrapping.
module rr_prio_pick
  import rr_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQS = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] reqs,
  input  logic [IDX_W-1:0]    start,
  output logic [NUM_REQS-1:0] onehot_c,
  output logic [IDX_W-1:0]    idx_c,
  output logic                found_c
);

  int unsigned cand;

  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    found_c  = 1'b0;
    cand     = 0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      cand = 32'(start) + k;
      if (cand >= NUM_REQS) cand = cand - NUM_REQS;
      if (!found_c && reqs[IDX_W'(cand)]) begin
        found_c                  = 1'b1;
        idx_c                    = IDX_W'(cand);
        onehot_c[IDX_W'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: owner holds the grant for up to weight acked beats.
// Optional RR_ARB_LOCK_EN adds a lock input that extends the current tenure.
module wrr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned WEIGHT_W = 3
) (
  input logic          clk,
  input logic          reset,
  wrr_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQS);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NUM_REQS-1:0] grants_q, grants_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic                lock_c;
  logic                release_c;
  logic [IDX_W-1:0]    next_ptr_c;
  logic [IDX_W-1:0]    pick_start_c;
  logic [NUM_REQS-1:0] pick_reqs_c;
  logic [NUM_REQS-1:0] pick_onehot_c;
  logic [IDX_W-1:0]    pick_idx_c;
  logic                pick_found_c;
  logic [WEIGHT_W-1:0] pick_weight_c;
  logic [WEIGHT_W-1:0] pick_credit_c;

`ifdef RR_ARB_LOCK_EN
  assign lock_c = bus.lock;
`else
  assign lock_c = 1'b0;
`endif

  // Release when the owner drops its request, or on its last acked beat unless locked.
  assign release_c = (state_q == ARB_OWN) &&
                     (!bus.reqs[owner_q] ||
                      (bus.ack && (credit_q == WEIGHT_W'(1)) && !lock_c));

  assign next_ptr_c   = IDX_W'(wrap_inc(32'(owner_q), NUM_REQS));
  assign pick_start_c = release_c ? next_ptr_c : ptr_q;
  assign pick_reqs_c  = release_c ? (bus.reqs & ~grants_q) : bus.reqs;

  rr_prio_pick #(.NUM_REQS(NUM_REQS)) u_pick (
    .reqs     (pick_reqs_c),
    .start    (pick_start_c),
    .onehot_c (pick_onehot_c),
    .idx_c    (pick_idx_c),
    .found_c  (pick_found_c)
  );

  // A zero weight still earns one beat.
  assign pick_weight_c = bus.weights[32'(pick_idx_c)*WEIGHT_W +: WEIGHT_W];
  assign pick_credit_c = (pick_weight_c == '0) ? WEIGHT_W'(1) : pick_weight_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      grants_q <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grants_q <= grants_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grants_d = grants_q;
    credit_d = credit_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found_c) begin
          state_d  = ARB_OWN;
          owner_d  = pick_idx_c;
          grants_d = pick_onehot_c;
          credit_d = pick_credit_c;
        end
      end
      ARB_OWN: begin
        if (release_c) begin
          ptr_d = next_ptr_c;
          if (pick_found_c) begin
            owner_d  = pick_idx_c;
            grants_d = pick_onehot_c;
            credit_d = pick_credit_c;
          end else begin
            state_d  = ARB_IDLE;
            owner_d  = '0;
            grants_d = '0;
            credit_d = '0;
          end
        end else if (bus.ack && (credit_q > WEIGHT_W'(1))) begin
          // Under lock the credit saturates at 1 instead of releasing.
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.grants      = grants_q;
  assign bus.grant_valid = (state_q == ARB_OWN);
  assign bus.grant_idx   = owner_q;
  assign bus.credit_left = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a tenure-level reference model.
module tb_wrr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned WW = 3;

  logic clk;
  logic rst_v;
  logic [NR-1:0]    reqs_v;
  logic [NR*WW-1:0] weights_v;
  logic             ack_v;
  logic             lock_v;

  int n_cmp;
  int n_err;

  wrr_arbiter_if #(.NUM_REQS(NR), .WEIGHT_W(WW)) bus ();

  assign bus.reqs    = reqs_v;
  assign bus.weights = weights_v;
  assign bus.ack     = ack_v;
`ifdef RR_ARB_LOCK_EN
  assign bus.lock    = lock_v;
`endif

  wrr_arbiter #(.NUM_REQS(NR), .WEIGHT_W(WW)) dut (
    .clk   (clk),
    .reset (rst_v),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: who owns, how many beats remain, where the scan starts.
  bit m_own;
  int m_owner;
  int m_credit;
  int m_ptr;

  function automatic int pick(input logic [NR-1:0] r, input int start);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (start + k) % NR;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic int wload(input int i);
    int w;
    w = int'((weights_v >> (i * WW)) & 12'h7);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_update();
    int p;
    if (!rst_v) begin
      m_own = 0; m_owner = 0; m_credit = 0; m_ptr = 0;
    end else if (!m_own) begin
      p = pick(reqs_v, m_ptr);
      if (p >= 0) begin m_own = 1; m_owner = p; m_credit = wload(p); end
    end else if (!reqs_v[m_owner] || (ack_v && m_credit == 1 && !lock_v)) begin
      m_ptr = (m_owner + 1) % NR;
      p = pick(reqs_v & ~(4'b0001 << m_owner), m_ptr);
      if (p >= 0) begin m_owner = p; m_credit = wload(p); end
      else begin m_own = 0; m_owner = 0; m_credit = 0; end
    end else if (ack_v && m_credit > 1) begin
      m_credit = m_credit - 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic check_out(input string tag, input logic [NR-1:0] eg, input int ec);
    check({tag, "_grants"}, 32'(bus.grants), 32'(eg));
    check({tag, "_valid"},  32'(bus.grant_valid), 32'(eg != 0));
    check({tag, "_idx"},    32'(bus.grant_idx), 32'(idx_of(eg)));
    check({tag, "_credit"}, 32'(bus.credit_left), 32'(ec));
  endtask

  task automatic drive(input logic r, input logic [NR-1:0] q, input logic [NR*WW-1:0] w,
                       input logic a, input logic l);
    rst_v = r; reqs_v = q; weights_v = w; ack_v = a; lock_v = l;
  endtask

  typedef struct {
    logic             rst;
    logic [NR-1:0]    reqs;
    logic [NR*WW-1:0] w;
    logic             ack;
    logic [NR-1:0]    eg;
    int               ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [NR-1:0] q, input logic [NR*WW-1:0] w,
                     input logic a, input logic [NR-1:0] eg, input int ec);
    vec_t v;
    v.rst = r; v.reqs = q; v.w = w; v.ack = a; v.eg = eg; v.ec = ec;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Reset with all requesting, then weight-2 rotation with constant ack.
    add(0, 4'b1111, 12'h492, 0, 4'b0000, 0);
    add(0, 4'b1111, 12'h492, 0, 4'b0000, 0);
    add(1, 4'b1111, 12'h492, 1, 4'b0001, 2);
    add(1, 4'b1111, 12'h492, 1, 4'b0001, 1);
    add(1, 4'b1111, 12'h492, 1, 4'b0010, 2);
    add(1, 4'b1111, 12'h492, 1, 4'b0010, 1);
    add(1, 4'b1111, 12'h492, 1, 4'b0100, 2);
    add(1, 4'b1111, 12'h492, 1, 4'b0100, 1);
    add(1, 4'b1111, 12'h492, 1, 4'b1000, 2);
    add(1, 4'b1111, 12'h492, 1, 4'b1000, 1);
    add(1, 4'b1111, 12'h492, 1, 4'b0001, 2);
    // Zero weights act as one beat.
    add(0, 4'b0101, 12'h000, 1, 4'b0000, 0);
    add(1, 4'b0101, 12'h000, 1, 4'b0001, 1);
    add(1, 4'b0101, 12'h000, 1, 4'b0100, 1);
    add(1, 4'b0101, 12'h000, 1, 4'b0001, 1);
    add(1, 4'b0101, 12'h000, 1, 4'b0100, 1);
    // Early drop hands over with fresh credit and no bubble.
    add(0, 4'b0011, 12'h6DB, 0, 4'b0000, 0);
    add(1, 4'b0011, 12'h6DB, 0, 4'b0001, 3);
    add(1, 4'b0011, 12'h6DB, 1, 4'b0001, 2);
    add(1, 4'b0010, 12'h6DB, 1, 4'b0010, 3);
    // Drive pointer to 3, wrap to 0, go idle, reset mid-tenure restores pointer 0.
    add(0, 4'b0100, 12'h249, 1, 4'b0000, 0);
    add(1, 4'b0100, 12'h249, 1, 4'b0100, 1);
    add(1, 4'b1001, 12'h249, 1, 4'b1000, 1);
    add(1, 4'b1001, 12'h249, 1, 4'b0001, 1);
    add(1, 4'b0000, 12'h249, 1, 4'b0000, 0);
    add(1, 4'b1111, 12'h249, 0, 4'b0010, 1);
    add(0, 4'b1111, 12'h249, 0, 4'b0000, 0);
    add(1, 4'b1111, 12'h249, 0, 4'b0001, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].reqs, vecs[i].w, vecs[i].ack, 1'b0);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].eg, vecs[i].ec);
    end

    // No ack holds credit; late arrivals do not pre-empt the owner.
    drive(1'b0, 4'b0001, 12'h6DB, 1'b0, 1'b0); step();
    drive(1'b1, 4'b0001, 12'h6DB, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("hold", 4'b0001, 3);
    end
    ack_v = 1'b1; step();
    check_out("hold_ack", 4'b0001, 2);
    reqs_v = 4'b1111; ack_v = 1'b0; step();
    check_out("no_preempt", 4'b0001, 2);

`ifdef RR_ARB_LOCK_EN
    // Lock keeps a weight-1 owner across several acks.
    drive(1'b0, 4'b1100, 12'h249, 1'b0, 1'b1); step();
    drive(1'b1, 4'b1100, 12'h249, 1'b0, 1'b1); step();
    check_out("lock_own", 4'b0100, 1);
    ack_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("lock_hold", 4'b0100, 1);
    end
    lock_v = 1'b0; step();
    check_out("lock_rel", 4'b1000, 1);
`endif

    // Randomized traffic against the model.
    drive(1'b0, '0, 12'(($urandom)), 1'b0, 1'b0); step();
    rst_v = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NR; b++)
        if ($urandom_range(0, 7) == 0) reqs_v[b] = ~reqs_v[b];
      ack_v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) weights_v = 12'($urandom);
      rst_v = ($urandom_range(0, 199) != 0);
`ifdef RR_ARB_LOCK_EN
      lock_v = ($urandom_range(0, 3) == 0);
`endif
      step();
      check_out("rand", m_own ? NR'(4'b0001 << m_owner) : NR'(0), m_credit);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
